// File: rtl/lut_sched_pkg.sv
// Shared definitions for the LUT layer scheduler.
//   state_t        : scheduler FSM states
//   DEF_*          : default layer geometry
//   ADDR_W/SLOT_W/CFG_W : LUT address, activation slot index and config data widths
//   conn_t         : one neuron's connectivity row (FAN_IN x SLOT_W) at default geometry
//   max_u()        : width helper for the shared config data port
package lut_sched_pkg;

  typedef enum logic [1:0] {IDLE, EVAL, DRAIN, OUT} state_t;

  localparam int unsigned DEF_NUM_NEURONS = 64;
  localparam int unsigned DEF_FAN_IN      = 4;
  localparam int unsigned DEF_IN_BITS     = 2;
  localparam int unsigned DEF_OUT_BITS    = 2;
  localparam int unsigned DEF_VEC_SLOTS   = 64;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned ADDR_W = DEF_FAN_IN * DEF_IN_BITS;
  localparam int unsigned SLOT_W = $clog2(DEF_VEC_SLOTS);
  localparam int unsigned CFG_W  = max_u(DEF_OUT_BITS, SLOT_W);

  typedef logic [DEF_FAN_IN-1:0][SLOT_W-1:0] conn_t;

endpackage

// File: rtl/lut_layer_scheduler_truth_ram.sv
// Shared truth-table RAM for all neurons of the layer (distributed RAM).
// Address = {neuron, lut_entry}; contents are not reset.
//   clk    : clock
//   we     : write strobe
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address, registered read (data valid the next cycle)
//   rdata  : read data
module lut_truth_ram
  import lut_sched_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_NUM_NEURONS << ADDR_W,
  parameter int unsigned AW    = $clog2(DEF_NUM_NEURONS) + ADDR_W,
  parameter int unsigned DW    = DEF_OUT_BITS
)(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/lut_layer_scheduler.sv
// Time-multiplexed evaluator for one LogicNets layer. A captured activation
// vector is walked one neuron per cycle: the neuron's connectivity row selects
// FAN_IN activation slots, which form the address into the shared truth RAM.
// Results are assembled into m_data and presented with a valid/ready handshake.
//   clk, rst_n        : clock, asynchronous active-low reset
//   s_valid/s_ready/s_data : input activation vector stream
//   m_valid/m_ready/m_data : output vector stream, neuron n at m_data[n*OUT_BITS +: OUT_BITS]
//   cfg_we, cfg_sel, cfg_neuron, cfg_addr, cfg_wdata : table write port (IDLE only)
//   cfg_err           : one-cycle pulse when a config access is rejected
// Optional macro CFG_READBACK_EN adds cfg_re / cfg_rdata table readback.
module lut_layer_scheduler
  import lut_sched_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int unsigned FAN_IN      = DEF_FAN_IN,
  parameter int unsigned IN_BITS     = DEF_IN_BITS,
  parameter int unsigned OUT_BITS    = DEF_OUT_BITS,
  parameter int unsigned VEC_SLOTS   = DEF_VEC_SLOTS
)(
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       s_valid,
  output logic                                       s_ready,
  input  logic [VEC_SLOTS*IN_BITS-1:0]               s_data,
  output logic                                       m_valid,
  input  logic                                       m_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0]            m_data,
  input  logic                                       cfg_we,
  input  logic                                       cfg_sel,
  input  logic [$clog2(NUM_NEURONS)-1:0]             cfg_neuron,
  input  logic [FAN_IN*IN_BITS-1:0]                  cfg_addr,
  input  logic [max_u(OUT_BITS,$clog2(VEC_SLOTS))-1:0] cfg_wdata,
  output logic                                       cfg_err
`ifdef CFG_READBACK_EN
  ,
  input  logic                                       cfg_re,
  output logic [max_u(OUT_BITS,$clog2(VEC_SLOTS))-1:0] cfg_rdata
`endif
);

  localparam int unsigned NW  = $clog2(NUM_NEURONS);
  localparam int unsigned AW  = FAN_IN * IN_BITS;
  localparam int unsigned SW  = $clog2(VEC_SLOTS);
  localparam int unsigned CW  = max_u(OUT_BITS, SW);
  localparam int unsigned FW  = (FAN_IN > 1) ? $clog2(FAN_IN) : 1;
  localparam int unsigned RAW = NW + AW;

  typedef logic [FAN_IN-1:0][SW-1:0] row_t;

  state_t               state;
  logic [NW-1:0]        cnt;
  logic [NW-1:0]        wr_idx;
  logic [IN_BITS-1:0]   act [VEC_SLOTS];
  row_t                 conn_mem [NUM_NEURONS];
  row_t                 conn_rd;
  logic [AW-1:0]        gather;
  logic [RAW-1:0]       t_raddr;
  logic                 t_we;
  logic [OUT_BITS-1:0]  t_rdata;
  logic                 idle;
  logic                 cfg_wr_ok;
  logic                 cfg_bad;

  assign idle      = (state == IDLE);
  // A config write in IDLE takes the cycle, so the input vector waits.
  assign s_ready   = rst_n & idle & ~cfg_we;
  assign cfg_wr_ok = idle & cfg_we;
  assign t_we      = cfg_wr_ok & ~cfg_sel;

  always_ff @(posedge clk) begin
    if (cfg_wr_ok && cfg_sel)
      conn_mem[cfg_neuron][cfg_addr[FW-1:0]] <= cfg_wdata[SW-1:0];
  end

  always_ff @(posedge clk) begin
    if (s_valid && s_ready) begin
      for (int unsigned k = 0; k < VEC_SLOTS; k++)
        act[k] <= s_data[k*IN_BITS +: IN_BITS];
    end
  end

  assign conn_rd = conn_mem[cnt];

  // idx[0] lands in the LSBs of the LUT address; slots past VEC_SLOTS read 0.
  for (genvar gi = 0; gi < FAN_IN; gi++) begin : g_gather
    logic [SW-1:0] idx;
    assign idx = conn_rd[gi];
    if ((2**SW) > VEC_SLOTS) begin : g_chk
      assign gather[gi*IN_BITS +: IN_BITS] = (idx <= SW'(VEC_SLOTS-1)) ? act[idx] : '0;
    end else begin : g_full
      assign gather[gi*IN_BITS +: IN_BITS] = act[idx];
    end
  end

`ifdef CFG_READBACK_EN
  // The single read port is borrowed for readback while IDLE.
  assign t_raddr = idle ? {cfg_neuron, cfg_addr} : {cnt, gather};
`else
  assign t_raddr = {cnt, gather};
`endif

  lut_truth_ram #(
    .DEPTH (NUM_NEURONS << AW),
    .AW    (RAW),
    .DW    (OUT_BITS)
  ) u_truth (
    .clk   (clk),
    .we    (t_we),
    .waddr ({cfg_neuron, cfg_addr}),
    .wdata (cfg_wdata[OUT_BITS-1:0]),
    .raddr (t_raddr),
    .rdata (t_rdata)
  );

`ifdef CFG_READBACK_EN
  assign cfg_bad = (cfg_we | cfg_re) & ~idle;
`else
  assign cfg_bad = cfg_we & ~idle;
`endif

  // Truth RAM output lags the address by one cycle, so each EVAL cycle stores
  // the previous neuron's result and DRAIN stores the last one.
  assign wr_idx = cnt - 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_bad;
      case (state)
        IDLE: begin
          if (s_valid && s_ready) begin
            state <= EVAL;
            cnt   <= '0;
          end
        end
        EVAL: begin
          if (cnt != '0)
            m_data[wr_idx*OUT_BITS +: OUT_BITS] <= t_rdata;
          if (cnt == NW'(NUM_NEURONS-1))
            state <= DRAIN;
          else
            cnt <= cnt + 1'b1;
        end
        DRAIN: begin
          m_data[(NUM_NEURONS-1)*OUT_BITS +: OUT_BITS] <= t_rdata;
          m_valid <= 1'b1;
          state   <= OUT;
        end
        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CFG_READBACK_EN
  logic          rb_truth_q;
  logic [CW-1:0] rb_hold;
  logic          rb_go;

  assign rb_go = idle & cfg_re & ~cfg_we;

  // Truth data shows straight from the RAM register for one cycle, then is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_truth_q <= 1'b0;
      rb_hold    <= '0;
    end else begin
      rb_truth_q <= rb_go & ~cfg_sel;
      if (rb_truth_q)
        rb_hold <= CW'(t_rdata);
      if (rb_go && cfg_sel)
        rb_hold <= CW'(conn_mem[cfg_neuron][cfg_addr[FW-1:0]]);
    end
  end

  assign cfg_rdata = rb_truth_q ? CW'(t_rdata) : rb_hold;
`endif

endmodule
